// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//   Upstream controller for an external MAC16 DSP tile. Each accepted sample is
//   written into a circular delay line, then TAPS sample/coefficient operand
//   pairs are streamed into the MAC (first pair loads, the rest accumulate).
//   After MAC_LAT drain cycles the 32-bit accumulator is arithmetically
//   shifted by SHIFT, saturated to 16 bits and emitted as one output sample.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      sample handshake; in_ready is high only in IDLE
//   in_sample              signed 16-bit input sample
//   coef_we/addr/data      coefficient write port, honoured only in IDLE
//   mac_a, mac_b           registered MAC operands (delayed sample, coefficient)
//   mac_ce, mac_load       MAC accumulate enable / load-instead-of-add
//   mac_result             signed 32-bit MAC accumulator
//   out_valid/out_sample   one-cycle result pulse and held filtered sample
//   busy                   high while a pass is running (RUN or DRAIN)
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter  int TAPS    = 8,
  parameter  int SHIFT   = 15,
  parameter  int MAC_LAT = 1,
  localparam int AW      = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_sample,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [15:0]   coef_data,
  output logic [15:0]   mac_a,
  output logic [15:0]   mac_b,
  output logic          mac_ce,
  output logic          mac_load,
  input  logic [31:0]   mac_result,
  output logic          out_valid,
  output logic [15:0]   out_sample,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] k_q;        // tap index currently presented on mac_a/mac_b
  logic [1:0]    drain_q;    // DRAIN cycle counter, 0 .. MAC_LAT-1

  logic [15:0]   delay_q [TAPS];
  logic [15:0]   coef_q  [TAPS];

  logic [15:0]   mac_a_q;
  logic [15:0]   mac_b_q;
  logic          mac_ce_q;
  logic          mac_load_q;
  logic          out_valid_q;
  logic [15:0]   out_sample_q;

  logic          accept;
  logic [AW-1:0] k_next;
  logic [AW-1:0] rd_idx;
  logic [15:0]   coef0_eff;
  logic [31:0]   shifted;
  logic [15:0]   sat_val;

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready = rst_n && (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;

  // Next tap and its delay-line slot; TAPS is a power of two so the pointer
  // subtraction wraps modulo TAPS for free.
  assign k_next   = k_q + 1'b1;
  assign rd_idx   = wr_ptr_q - k_next;

  // A coefficient written in the accept cycle must already be seen by tap 0.
  assign coef0_eff = (coef_we && (coef_addr == '0)) ? coef_data : coef_q[0];

  assign shifted = 32'($signed(mac_result) >>> SHIFT);

  always_comb begin
    // NOTE: assign a default before any branch so every path drives sat_val;
    // a missing default in combinational logic infers a latch.
    sat_val = shifted[15:0];
    if ($signed(shifted) > 32'sd32767) begin
      sat_val = 16'h7FFF;
    end else if ($signed(shifted) < -32'sd32768) begin
      sat_val = 16'h8000;
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      k_q          <= '0;
      drain_q      <= '0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_ce_q     <= 1'b0;
      mac_load_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      // NOTE: the delay line and coefficients are small register files that
      // must read as zero after reset, so they are cleared here rather than
      // left uninitialised like a RAM macro would be.
      for (int i = 0; i < TAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coef_we) begin
            coef_q[coef_addr] <= coef_data;
          end
          if (accept) begin
            delay_q[wr_ptr_q] <= in_sample;
            // Tap 0 is the sample arriving right now.
            mac_a_q    <= in_sample;
            mac_b_q    <= coef0_eff;
            mac_ce_q   <= 1'b1;
            mac_load_q <= 1'b1;
            k_q        <= '0;
            state_q    <= RUN;
          end
        end

        RUN: begin
          if (k_q == AW'(TAPS - 1)) begin
            // Last pair was presented this cycle; freeze the accumulator and
            // keep the operands where they are.
            mac_ce_q   <= 1'b0;
            mac_load_q <= 1'b0;
            drain_q    <= '0;
            state_q    <= DRAIN;
          end else begin
            k_q        <= k_next;
            mac_a_q    <= delay_q[rd_idx];
            mac_b_q    <= coef_q[k_next];
            mac_load_q <= 1'b0;
          end
        end

        DRAIN: begin
          if (drain_q == 2'(MAC_LAT - 1)) begin
            out_sample_q <= sat_val;
            out_valid_q  <= 1'b1;
            wr_ptr_q     <= wr_ptr_q + 1'b1;
            k_q          <= '0;
            state_q      <= IDLE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign mac_ce     = mac_ce_q;
  assign mac_load   = mac_load_q;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sequencer
//   Directed bench for fir_mac_sequencer (TAPS=8, SHIFT=15, MAC_LAT=1) with a
//   behavioural one-cycle MAC16 model. Stimulus pushes hand-computed expected
//   samples into a queue; an independent monitor pops and compares them (and
//   the accept-to-output latency) whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;

  localparam int TAPS    = 8;
  localparam int SHIFT   = 15;
  localparam int MAC_LAT = 1;
  localparam int AW      = $clog2(TAPS);
  localparam int PERIOD  = TAPS + MAC_LAT + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_sample;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_data;
  logic [15:0]   mac_a;
  logic [15:0]   mac_b;
  logic          mac_ce;
  logic          mac_load;
  logic [31:0]   mac_result;
  logic          out_valid;
  logic [15:0]   out_sample;
  logic          busy;

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .TAPS    (TAPS),
    .SHIFT   (SHIFT),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_ce     (mac_ce),
    .mac_load   (mac_load),
    .mac_result (mac_result),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .busy       (busy)
  );

  // MAC16 model: 16x16 signed product, load or accumulate, wraps at 32 bits.
  logic signed [31:0] prod;
  logic signed [31:0] acc;
  assign prod       = $signed(mac_a) * $signed(mac_b);
  assign mac_result = acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (mac_ce) acc <= mac_load ? prod : acc + prod;
  end

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge counter and accept recorder.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc + 1);
  end

  // Monitor: compare each presented output against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        check("out_sample", {16'b0, out_sample}, {16'b0, exp_q.pop_front()});
        check("latency", cyc, acc_q.pop_front() + TAPS + MAC_LAT);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    check("rst_in_ready",   {31'b0, in_ready},  32'd0);
    check("rst_out_valid",  {31'b0, out_valid}, 32'd0);
    check("rst_out_sample", {16'b0, out_sample}, 32'd0);
    check("rst_mac_a",      {16'b0, mac_a},     32'd0);
    check("rst_mac_b",      {16'b0, mac_b},     32'd0);
    check("rst_mac_ce",     {31'b0, mac_ce},    32'd0);
    check("rst_mac_load",   {31'b0, mac_load},  32'd0);
    check("rst_busy",       {31'b0, busy},      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
    check("busy_after_reset",     {31'b0, busy},     32'd0);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Offer one sample; optionally write coef[0] in the same cycle. Returns the
  // accept edge index, or -1 if in_ready never came.
  task automatic send(input logic [15:0] s, input logic hold, input logic cw,
                      input logic [15:0] cd, output int t);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = s;
    if (cw) begin
      coef_we   = 1'b1;
      coef_addr = '0;
      coef_data = cd;
    end
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      coef_we  = 1'b0;
      t = -1;
    end else begin
      @(posedge clk);
      #1;
      t        = cyc;
      in_valid = hold;
      coef_we  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  logic [15:0] imp_coef [TAPS] = '{16'h0800, 16'h1000, 16'h1800, 16'h2000,
                                   16'h2800, 16'h3000, 16'h3800, 16'h4000};
  logic [15:0] imp_exp  [TAPS] = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000,
                                   16'h1400, 16'h1800, 16'h1C00, 16'h2000};

  task automatic impulse_test();
    int t;
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), imp_coef[k]);
    for (int n = 0; n < TAPS; n++) begin
      exp_q.push_back(imp_exp[n]);
      send((n == 0) ? 16'h4000 : 16'h0000, 1'b0, 1'b0, 16'h0, t);
    end
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    in_valid  = 1'b0;
    in_sample = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;

    // Single tap, coefficient written in the accept cycle.
    do_reset();
    exp_q.push_back(16'h0800);
    send(16'h1000, 1'b0, 1'b1, 16'h4000, t0);
    wait_drain();
    repeat (3) @(negedge clk);
    check("out_sample_hold", {16'b0, out_sample}, 32'h0800);

    // Impulse response reproduces the coefficients scaled by 0.5.
    do_reset();
    impulse_test();

    // Positive saturation.
    do_reset();
    write_coef(0, 16'h7FFF);
    write_coef(1, 16'h7FFF);
    exp_q.push_back(16'h7FFE);
    send(16'h7FFF, 1'b0, 1'b0, 16'h0, t0);
    exp_q.push_back(16'h7FFF);
    send(16'h7FFF, 1'b0, 1'b0, 16'h0, t0);
    wait_drain();

    // -1.0 * -1.0 overflows Q15.
    do_reset();
    write_coef(0, 16'h8000);
    exp_q.push_back(16'h7FFF);
    send(16'h8000, 1'b0, 1'b0, 16'h0, t0);
    wait_drain();

    // Negative saturation.
    do_reset();
    write_coef(0, 16'h8000);
    write_coef(1, 16'h8000);
    exp_q.push_back(16'h8001);
    send(16'h7FFF, 1'b0, 1'b0, 16'h0, t0);
    exp_q.push_back(16'h8000);
    send(16'h7FFF, 1'b0, 1'b0, 16'h0, t0);
    wait_drain();

    // in_valid held high: one accept per PERIOD cycles.
    do_reset();
    write_coef(0, 16'h4000);
    exp_q.push_back(16'h0800);
    send(16'h1000, 1'b1, 1'b0, 16'h0, t0);
    exp_q.push_back(16'h1000);
    send(16'h2000, 1'b1, 1'b0, 16'h0, t1);
    exp_q.push_back(16'h1800);
    send(16'h3000, 1'b0, 1'b0, 16'h0, t2);
    check("accept_spacing_1", t1 - t0, PERIOD);
    check("accept_spacing_2", t2 - t1, PERIOD);
    wait_drain();

    // Coefficient write while busy is dropped.
    do_reset();
    write_coef(0, 16'h4000);
    exp_q.push_back(16'h0800);
    send(16'h1000, 1'b0, 1'b0, 16'h0, t0);
    check("busy_in_run", {31'b0, busy}, 32'd1);
    write_coef(0, 16'h7FFF);
    wait_drain();
    exp_q.push_back(16'h0800);
    send(16'h1000, 1'b0, 1'b0, 16'h0, t0);
    wait_drain();

    // Reset at RUN k=3 aborts the pass; afterwards everything starts clean.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), imp_coef[k]);
    send(16'h4000, 1'b0, 1'b0, 16'h0, t0);
    check("run_k0_mac_a",    {16'b0, mac_a},    32'h4000);
    check("run_k0_mac_b",    {16'b0, mac_b},    32'h0800);
    check("run_k0_mac_load", {31'b0, mac_load}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("run_k3_mac_b",    {16'b0, mac_b},    32'h2000);
    check("run_k3_mac_load", {31'b0, mac_load}, 32'd0);
    check("run_k3_mac_ce",   {31'b0, mac_ce},   32'd1);
    do_reset();
    repeat (2 * PERIOD) @(negedge clk);
    impulse_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
